// File: rtl/crp16_alu_pkg.sv
// rtl/crp16_alu_pkg.sv - shared CRP16 ALU op-select codes and multiply sequencer states
package crp16_alu_pkg;

   // ALU op-select encoding seen on crp16_alu op_sel
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_LSR = 3'b010;
   localparam logic [2:0] ALU_ASR = 3'b011;
   localparam logic [2:0] ALU_LSL = 3'b100;
   localparam logic [2:0] ALU_AND = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;

   localparam int unsigned DATA_W = 16;

   // Shift distance used for every single-step shift the sequencer issues
   localparam logic [DATA_W-1:0] SHIFT_ONE = 16'd1;

   // Multiply sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADD  = 3'd1,
      ST_SHL  = 3'd2,
      ST_SHR  = 3'd3,
      ST_DONE = 3'd4
   } mul_state_t;

   // State that follows a multiplier value: finished when no bits remain,
   // otherwise add if the current low bit is set, else go straight to the shift
   function automatic mul_state_t next_iter_state(input logic [DATA_W-1:0] mplier_val);
      if (mplier_val == '0)
         return ST_DONE;
      else if (mplier_val[0])
         return ST_ADD;
      else
         return ST_SHL;
   endfunction

endpackage

// File: rtl/crp16_mul_seq.sv
// rtl/crp16_mul_seq.sv - shift-and-add 16x16 multiply driving an external crp16_alu
//
// The ALU operand/op-select outputs are registered together with the state
// transition, so during each state they already carry that state's operation
// and alu_out/alu_c/alu_z can be captured at the end of the same cycle.
module crp16_mul_seq
   import crp16_alu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] a_in,
   input  logic [15:0] b_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        ovf,
   output logic [15:0] alu_op_a,
   output logic [15:0] alu_op_b,
   output logic [2:0]  alu_op_sel,
   input  logic [15:0] alu_out,
   input  logic        alu_c,
   input  logic        alu_z
);

   mul_state_t  state;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic [15:0] acc;
   logic        ovf_r;

   // A bit leaves the top of mcand while higher multiplier bits are still
   // pending: some later partial product is >= 2^16, so the product overflows
   logic        shl_loses_bit;
   assign shl_loses_bit = mcand[15] & (|mplier[15:1]);

   // Sequencer: state, working registers and all registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         mcand      <= '0;
         mplier     <= '0;
         acc        <= '0;
         ovf_r      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         ovf        <= 1'b0;
         alu_op_a   <= '0;
         alu_op_b   <= '0;
         alu_op_sel <= ALU_ADD;
      end else begin
         unique case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= a_in;
                  mplier <= b_in;
                  acc    <= '0;
                  ovf_r  <= 1'b0;
                  busy   <= 1'b1;
                  state  <= next_iter_state(b_in);
                  unique case (next_iter_state(b_in))
                     ST_ADD: begin
                        // acc is being cleared, so the first add is 0 + a_in
                        alu_op_a   <= '0;
                        alu_op_b   <= a_in;
                        alu_op_sel <= ALU_ADD;
                     end
                     ST_SHL: begin
                        alu_op_a   <= a_in;
                        alu_op_b   <= SHIFT_ONE;
                        alu_op_sel <= ALU_LSL;
                     end
                     default: begin
                        // Zero multiplier: finish immediately with a zero product
                        done       <= 1'b1;
                        result     <= '0;
                        ovf        <= 1'b0;
                        alu_op_a   <= '0;
                        alu_op_b   <= '0;
                        alu_op_sel <= ALU_ADD;
                     end
                  endcase
               end
            end

            ST_ADD: begin
               acc        <= alu_out;
               ovf_r      <= ovf_r | alu_c;
               state      <= ST_SHL;
               alu_op_a   <= mcand;
               alu_op_b   <= SHIFT_ONE;
               alu_op_sel <= ALU_LSL;
            end

            ST_SHL: begin
               mcand      <= alu_out;
               ovf_r      <= ovf_r | shl_loses_bit;
               state      <= ST_SHR;
               alu_op_a   <= mplier;
               alu_op_b   <= SHIFT_ONE;
               alu_op_sel <= ALU_LSR;
            end

            ST_SHR: begin
               mplier <= alu_out;
               if (alu_z) begin
                  state      <= ST_DONE;
                  done       <= 1'b1;
                  result     <= acc;
                  ovf        <= ovf_r;
                  alu_op_a   <= '0;
                  alu_op_b   <= '0;
                  alu_op_sel <= ALU_ADD;
               end else if (alu_out[0]) begin
                  state      <= ST_ADD;
                  alu_op_a   <= acc;
                  alu_op_b   <= mcand;
                  alu_op_sel <= ALU_ADD;
               end else begin
                  state      <= ST_SHL;
                  alu_op_a   <= mcand;
                  alu_op_b   <= SHIFT_ONE;
                  alu_op_sel <= ALU_LSL;
               end
            end

            ST_DONE: begin
               // start is ignored here; it is honoured in the following IDLE cycle
               state      <= ST_IDLE;
               busy       <= 1'b0;
               done       <= 1'b0;
               alu_op_a   <= '0;
               alu_op_b   <= '0;
               alu_op_sel <= ALU_ADD;
            end

            default: begin
               state      <= ST_IDLE;
               busy       <= 1'b0;
               done       <= 1'b0;
               alu_op_a   <= '0;
               alu_op_b   <= '0;
               alu_op_sel <= ALU_ADD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crp16_mul_seq.sv
// tb/tb_crp16_mul_seq.sv - scoreboard bench for crp16_mul_seq with a behavioural ALU
module tb_crp16_mul_seq;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_LSR = 3'b010;
   localparam logic [2:0] OP_LSL = 3'b100;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        ovf;
   logic [15:0] alu_op_a;
   logic [15:0] alu_op_b;
   logic [2:0]  alu_op_sel;
   logic [15:0] alu_out;
   logic        alu_c;
   logic        alu_z;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [15:0]  res;
      logic         ovf;
      int           n;
      logic [191:0] seq;
      int           start_cyc;
   } exp_t;

   exp_t sb[$];

   crp16_mul_seq dut (
      .clock(clock), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .result(result), .ovf(ovf),
      .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_sel(alu_op_sel),
      .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural crp16_alu
   logic [16:0] alu_t;
   always_comb begin
      alu_t = 17'd0;
      case (alu_op_sel)
         3'b000: alu_t = {1'b0, alu_op_a} + {1'b0, alu_op_b};
         3'b001: alu_t = {1'b0, alu_op_a} - {1'b0, alu_op_b};
         3'b010: alu_t = {1'b0, alu_op_a >> alu_op_b[3:0]};
         3'b011: alu_t = {1'b0, 16'($signed(alu_op_a) >>> alu_op_b[3:0])};
         3'b100: alu_t = {1'b0, alu_op_a << alu_op_b[3:0]};
         3'b101: alu_t = {1'b0, alu_op_a & alu_op_b};
         3'b110: alu_t = {1'b0, alu_op_a | alu_op_b};
         default: alu_t = {1'b0, alu_op_a ^ alu_op_b};
      endcase
      alu_out = alu_t[15:0];
      alu_c   = alu_t[16];
      alu_z   = (alu_t[15:0] == 16'd0);
   end

   // Reference: product by plain arithmetic, op sequence from the multiplier bits
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int sc);
      exp_t        e;
      logic [31:0] p;
      int          top;
      p = 32'(a) * 32'(b);
      e.res = p[15:0];
      e.ovf = (p > 32'h0000_FFFF);
      e.n = 0;
      e.seq = '0;
      e.start_cyc = sc;
      top = -1;
      for (int i = 0; i < 16; i++) if (b[i]) top = i;
      for (int i = 0; i <= top; i++) begin
         if (b[i]) begin
            e.seq[e.n*3 +: 3] = OP_ADD;
            e.n++;
         end
         e.seq[e.n*3 +: 3] = OP_LSL;
         e.n++;
         e.seq[e.n*3 +: 3] = OP_LSR;
         e.n++;
      end
      return e;
   endfunction

   // Monitor: sample at negedge, compare against the scoreboard
   logic [191:0] cur_seq = '0;
   int           cur_n = 0;
   logic         prev_done = 1'b0;
   logic [15:0]  last_res = '0;
   logic         last_ovf = 1'b0;
   exp_t         e_m;

   always @(negedge clock) begin
      if (reset) begin
         checks++;
         if (busy || done || result != 16'd0 || ovf || alu_op_a != 16'd0 ||
             alu_op_b != 16'd0 || alu_op_sel != 3'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b done=%0b result=%h ovf=%0b alu=%h/%h/%b want all zero",
                     busy, done, result, ovf, alu_op_a, alu_op_b, alu_op_sel);
         end
         sb.delete();
         cur_n = 0;
         cur_seq = '0;
         prev_done = 1'b0;
      end else begin
         if (prev_done) begin
            checks++;
            if (busy || result != last_res || ovf != last_ovf) begin
               errors++;
               $display("FAIL result_hold: got busy=%0b result=%h ovf=%0b want busy=0 result=%h ovf=%0b",
                        busy, result, ovf, last_res, last_ovf);
            end
         end
         if (busy && !done) begin
            if (cur_n < 64) cur_seq[cur_n*3 +: 3] = alu_op_sel;
            cur_n++;
         end else begin
            checks++;
            if (alu_op_a != 16'd0 || alu_op_b != 16'd0 || alu_op_sel != 3'd0) begin
               errors++;
               $display("FAIL alu_quiet: got %h/%h/%b want 0000/0000/000", alu_op_a, alu_op_b, alu_op_sel);
            end
         end
         if (done) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: got done with result=%h want no pending multiply", result);
            end else begin
               e_m = sb.pop_front();
               if (!busy) begin
                  errors++;
                  $display("FAIL busy_in_done: got busy=0 want 1");
               end else if (result != e_m.res || ovf != e_m.ovf) begin
                  errors++;
                  $display("FAIL product: got result=%h ovf=%0b want result=%h ovf=%0b",
                           result, ovf, e_m.res, e_m.ovf);
               end else if ((cyc - e_m.start_cyc) != e_m.n) begin
                  errors++;
                  $display("FAIL latency: got %0d cycles want %0d", cyc - e_m.start_cyc, e_m.n);
               end else if (cur_n != e_m.n || cur_seq != e_m.seq) begin
                  errors++;
                  $display("FAIL op_sequence: got %0d ops seq=%h want %0d ops seq=%h",
                           cur_n, cur_seq, e_m.n, e_m.seq);
               end
               last_res = e_m.res;
               last_ovf = e_m.ovf;
            end
            cur_n = 0;
            cur_seq = '0;
         end
         prev_done = done;
      end
   end

   // Present a multiply and hold start until the DUT is idle and accepts it
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit hold);
      int guard;
      @(negedge clock);
      #1;
      a_in = a;
      b_in = b;
      start = 1'b1;
      guard = 0;
      while (busy) begin
         if (guard >= 300) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got busy=1 after %0d cycles want idle", guard);
            start = 1'b0;
            return;
         end
         @(negedge clock);
         #1;
         guard++;
      end
      @(posedge clock);
      #1;
      sb.push_back(model(a, b, cyc));
      if (!hold) begin
         @(negedge clock);
         #1;
         start = 1'b0;
      end
   endtask

   initial begin
      int guard;
      logic [15:0] ra, rb;
      reset = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clock);
      #1;
      reset = 1'b0;

      issue(16'd3, 16'd5, 1'b0);
      issue(16'h1234, 16'h0000, 1'b0);
      issue(16'hFFFF, 16'hFFFF, 1'b0);
      issue(16'h8000, 16'h0001, 1'b0);
      issue(16'h8000, 16'h0002, 1'b0);

      // start pulsed while busy must be ignored
      issue(16'd7, 16'd9, 1'b0);
      repeat (4) @(negedge clock);
      #1;
      a_in = 16'd1;
      b_in = 16'd1;
      start = 1'b1;
      @(negedge clock);
      #1;
      start = 1'b0;

      // reset in the middle of a long multiply, then a fresh one
      issue(16'hABCD, 16'hFFFF, 1'b0);
      repeat (6) @(negedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      #1;
      reset = 1'b0;
      issue(16'd7, 16'd9, 1'b0);

      // back-to-back with start held across DONE
      issue(16'd100, 16'd200, 1'b1);
      issue(16'h0123, 16'h0456, 1'b1);
      issue(16'h5555, 16'h0000, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rb = 16'($urandom_range(0, 15));
            1: rb = 16'($urandom);
            2: rb = 16'(1) << $urandom_range(0, 15);
            default: rb = 16'($urandom_range(0, 255));
         endcase
         issue(ra, rb, bit'($urandom_range(0, 1)));
      end

      @(negedge clock);
      #1;
      start = 1'b0;
      guard = 0;
      while ((sb.size() != 0 || busy) && guard < 300) begin
         @(negedge clock);
         guard++;
      end
      repeat (3) @(negedge clock);
      checks++;
      if (sb.size() != 0 || busy) begin
         errors++;
         $display("FAIL drain: got %0d pending busy=%0b want 0 pending busy=0", sb.size(), busy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
